// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output stage.
package audio_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned VOL_SHIFT  = 3;     // gain = vol / 8
    localparam int unsigned PEAK_DECAY = 2205;  // clk22K cycles per peak decay step

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } out_state_t;

    localparam sample_t SAT_MAX = 16'sh7FFF;
    localparam sample_t SAT_MIN = 16'sh8000;

    // Magnitude with the most negative code folded onto the most positive one
    function automatic sample_t abs_sat(input sample_t s);
        sample_t m;
        if (s == SAT_MIN) begin
            m = SAT_MAX;
        end else if (s < 0) begin
            m = -s;
        end else begin
            m = s;
        end
        return m;
    endfunction

    // Bit index of the highest set bit, 0 for a zero input
    function automatic logic [3:0] msb_index(input sample_t v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < int'(SAMPLE_W); i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees a slot for a same-cycle push.
module sample_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk22K,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push_c;
    logic              do_pop_c;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign dout      = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking
    always_ff @(posedge clk22K or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push_c) - (AW+1)'(do_pop_c);
        end
    end

    // Sample storage, no reset needed
    always_ff @(posedge clk22K) begin
        if (do_push_c) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/audio_output_stage.sv
// Audio output stage: volume/mute gain, sample FIFO and codec write FSM.
// Optional peak meter enabled by defining AUDIO_PEAK_METER_EN.
module audio_output_stage
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W     = SAMPLE_W,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                     clk22K,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic [3:0]               vol,
    input  logic                     mute,
    input  logic                     flag_clr,
    input  logic                     audio_out_allowed,
    output logic                     write_audio_out,
    output logic signed [DATA_W-1:0] left_data,
    output logic signed [DATA_W-1:0] right_data,
    output logic                     overflow,
    output logic                     underrun,
    output logic [3:0]               peak_level
);

    localparam int unsigned PROD_W = DATA_W + 5;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] shift_c;
    logic signed [DATA_W-1:0] scale_d, scale_q;
    logic                     push_v_q;

    logic [DATA_W-1:0]        fifo_dout;
    logic                     fifo_full;
    logic                     fifo_empty;

    out_state_t               state_d, state_q;
    logic                     pop_c;
    logic                     under_set_c;
    logic                     ovf_set_c;
    logic                     write_d, write_q;
    logic signed [DATA_W-1:0] data_d, data_q;
    logic                     overflow_q, underrun_q;

    // Gain and saturation of the incoming sample
    always_comb begin
        prod_c  = PROD_W'(sample_in) * PROD_W'($signed({1'b0, vol}));
        shift_c = prod_c >>> VOL_SHIFT;
        if (mute) begin
            scale_d = '0;
        end else if (shift_c > PROD_W'(SAT_MAX)) begin
            scale_d = DATA_W'(SAT_MAX);
        end else if (shift_c < PROD_W'(SAT_MIN)) begin
            scale_d = DATA_W'(SAT_MIN);
        end else begin
            scale_d = DATA_W'(shift_c);
        end
    end

    // Gain pipeline register and its valid
    always_ff @(posedge clk22K or posedge reset) begin
        if (reset) begin
            scale_q  <= '0;
            push_v_q <= 1'b0;
        end else begin
            scale_q  <= scale_d;
            push_v_q <= sample_valid;
        end
    end

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk22K (clk22K),
        .reset  (reset),
        .push   (push_v_q),
        .pop    (pop_c),
        .din    (scale_q),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Codec FSM: pop and latch in IDLE, strobe for one cycle in WRITE
    always_comb begin
        state_d     = state_q;
        pop_c       = 1'b0;
        under_set_c = 1'b0;
        write_d     = 1'b0;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (audio_out_allowed) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        data_d  = fifo_dout;
                        write_d = 1'b1;
                        state_d = WRITE;
                    end else begin
                        under_set_c = 1'b1;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO drops the sample unless this cycle's pop frees a slot
    assign ovf_set_c = push_v_q && fifo_full && !pop_c;

    // FSM state, codec outputs and sticky flags; clear wins over set
    always_ff @(posedge clk22K or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            data_q     <= data_d;
            overflow_q <= !flag_clr && (overflow_q || ovf_set_c);
            underrun_q <= !flag_clr && (underrun_q || under_set_c);
        end
    end

    assign write_audio_out = write_q;
    assign left_data       = data_q;
    assign right_data      = data_q;
    assign overflow        = overflow_q;
    assign underrun        = underrun_q;

`ifdef AUDIO_PEAK_METER_EN
    localparam int unsigned DEC_W = $clog2(PEAK_DECAY);
    localparam logic [DEC_W-1:0] DECAY_LAST = DEC_W'(PEAK_DECAY - 1);

    logic [DEC_W-1:0] decay_cnt_q;
    logic [3:0]       peak_q;
    logic [3:0]       level_c;

    assign level_c = msb_index(abs_sat(sample_t'(fifo_dout)));

    // Peak meter: load on a louder pop, otherwise step down once per decay period
    always_ff @(posedge clk22K or posedge reset) begin
        if (reset) begin
            peak_q      <= '0;
            decay_cnt_q <= '0;
        end else if (pop_c && (level_c > peak_q)) begin
            peak_q      <= level_c;
            decay_cnt_q <= '0;
        end else if (decay_cnt_q == DECAY_LAST) begin
            decay_cnt_q <= '0;
            if (peak_q != 4'd0) peak_q <= peak_q - 4'd1;
        end else begin
            decay_cnt_q <= decay_cnt_q + DEC_W'(1);
        end
    end

    assign peak_level = peak_q;
`else
    assign peak_level = 4'd0;
`endif

endmodule

// File: tb/tb_audio_output_stage.sv
// Self-checking bench for audio_output_stage with a queue-based reference model.
module tb_audio_output_stage;

    localparam int DEPTH = 8;
    localparam int DECAY = 2205;

    logic        clk22K = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [3:0]  vol = 4'd8;
    logic        mute = 1'b0;
    logic        flag_clr = 1'b0;
    logic        audio_out_allowed = 1'b0;
    logic        write_audio_out;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        overflow;
    logic        underrun;
    logic [3:0]  peak_level;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [15:0] got_q[$];
    logic [15:0] got_r[$];
    int          got_cyc[$];

    audio_output_stage dut (
        .clk22K            (clk22K),
        .reset             (reset),
        .sample_in         (sample_in),
        .sample_valid      (sample_valid),
        .vol               (vol),
        .mute              (mute),
        .flag_clr          (flag_clr),
        .audio_out_allowed (audio_out_allowed),
        .write_audio_out   (write_audio_out),
        .left_data         (left_data),
        .right_data        (right_data),
        .overflow          (overflow),
        .underrun          (underrun),
        .peak_level        (peak_level)
    );

    always #5 clk22K = ~clk22K;

    always @(posedge clk22K) cyc <= cyc + 1;

    // Record every cycle the codec strobe is seen high
    always @(negedge clk22K) begin
        if (!reset && write_audio_out === 1'b1) begin
            got_q.push_back(left_data);
            got_r.push_back(right_data);
            got_cyc.push_back(cyc);
        end
    end

    // Expected codec sample: floor(s * vol / 8) clamped to 16-bit signed range
    function automatic logic [15:0] ref_gain(input logic [15:0] s, input logic [3:0] v, input logic m);
        int p;
        if (m) return 16'h0000;
        p = int'($signed(s)) * int'(v);
        p = p >>> 3;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return 16'(p);
    endfunction

    // Expected meter level: position of the top set bit of |s|
    function automatic logic [3:0] ref_level(input logic [15:0] s);
        int mag;
        mag = int'($signed(s));
        if (mag < 0) mag = -mag;
        if (mag > 32767) mag = 32767;
        for (int i = 15; i > 0; i--) begin
            if (mag >= (1 << i)) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic step(input logic valid, input logic [15:0] s, input logic [3:0] v, input logic m);
        @(negedge clk22K);
        #1;
        sample_valid = valid;
        sample_in    = s;
        vol          = v;
        mute         = m;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'd8, 1'b0);
    endtask

    task automatic clear_mon;
        got_q.delete();
        got_r.delete();
        got_cyc.delete();
    endtask

    task automatic drain;
        audio_out_allowed = 1'b1;
        idle(2 * DEPTH + 6);
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
    endtask

    task automatic test_reset;
        idle(3);
        tests_run++;
        if ({write_audio_out, left_data, right_data, overflow, underrun, peak_level} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got wr=%b l=%h r=%h ovf=%b und=%b pk=%0d, want all 0",
                     write_audio_out, left_data, right_data, overflow, underrun, peak_level);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_passthrough;
        logic [15:0] sv [4];
        int c0;
        sv[0] = 16'h1234; sv[1] = 16'hFEDC; sv[2] = 16'h7FFF; sv[3] = 16'h8000;
        drain;
        clear_mon;
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, sv[i], 4'd8, 1'b0);
            if (i == 0) c0 = cyc;
        end
        idle(12);
        tests_run++;
        if (got_q.size() != 4) begin
            tests_failed++;
            $display("FAIL pass_count: got %0d strobes, want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== ref_gain(sv[i], 4'd8, 1'b0) || got_r[i] !== got_q[i]) begin
                tests_failed++;
                $display("FAIL pass_data[%0d]: got l=%h r=%h, want %h", i, got_q[i], got_r[i], sv[i]);
            end
            tests_run++;
            if (got_cyc[i] != c0 + 3 + 2 * i) begin
                tests_failed++;
                $display("FAIL pass_timing[%0d]: got cycle %0d, want %0d", i, got_cyc[i], c0 + 3 + 2 * i);
            end
        end
    endtask

    task automatic test_saturation;
        logic [15:0] sv [4];
        logic [3:0]  vv [4];
        logic [15:0] ev [4];
        sv[0] = 16'h7000; vv[0] = 4'd15; ev[0] = 16'h7FFF;
        sv[1] = 16'h9000; vv[1] = 4'd15; ev[1] = 16'h8000;
        sv[2] = 16'h0100; vv[2] = 4'd4;  ev[2] = 16'h0080;
        sv[3] = 16'h7FFF; vv[3] = 4'd0;  ev[3] = 16'h0000;
        drain;
        clear_mon;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, sv[i], vv[i], 1'b0);
            idle(1);
        end
        idle(8);
        tests_run++;
        if (got_q.size() != 4) begin
            tests_failed++;
            $display("FAIL sat_count: got %0d strobes, want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== ev[i]) begin
                tests_failed++;
                $display("FAIL sat_data[%0d]: got %h, want %h", i, got_q[i], ev[i]);
            end
        end
    endtask

    task automatic test_overflow;
        logic [15:0] sv [9];
        drain;
        audio_out_allowed = 1'b0;
        clear_mon;
        for (int i = 0; i < 9; i++) begin
            sv[i] = 16'($urandom);
            step(1'b1, sv[i], 4'd8, 1'b0);
        end
        idle(1);
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_before_drop: got %b, want 0", overflow);
        end
        idle(1);
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_after_drop: got %b, want 1", overflow);
        end
        audio_out_allowed = 1'b1;
        idle(25);
        tests_run++;
        if (got_q.size() != 8 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_drain: got %0d strobes ovf=%b, want 8 strobes ovf=1", got_q.size(), overflow);
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== sv[i]) begin
                tests_failed++;
                $display("FAIL ovf_data[%0d]: got %h, want %h", i, got_q[i], sv[i]);
            end
        end
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %b, want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop;
        logic [15:0] sv [9];
        drain;
        audio_out_allowed = 1'b0;
        clear_mon;
        for (int i = 0; i < 9; i++) begin
            sv[i] = 16'($urandom);
            step(1'b1, sv[i], 4'd8, 1'b0);
        end
        idle(1);
        audio_out_allowed = 1'b1;
        idle(30);
        tests_run++;
        if (got_q.size() != 9 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL fullpp_count: got %0d strobes ovf=%b, want 9 strobes ovf=0", got_q.size(), overflow);
        end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== sv[i]) begin
                tests_failed++;
                $display("FAIL fullpp_data[%0d]: got %h, want %h", i, got_q[i], sv[i]);
            end
        end
    endtask

    task automatic test_underrun;
        drain;
        audio_out_allowed = 1'b0;
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
        idle(3);
        tests_run++;
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL und_not_allowed: got %b, want 0", underrun);
        end
        clear_mon;
        audio_out_allowed = 1'b1;
        idle(3);
        tests_run++;
        if (underrun !== 1'b1 || got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL und_set: got und=%b strobes=%0d, want und=1 strobes=0", underrun, got_q.size());
        end
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
        tests_run++;
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL und_clear_priority: got %b, want 0", underrun);
        end
        idle(1);
        tests_run++;
        if (underrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL und_reset_again: got %b, want 1", underrun);
        end
    endtask

    task automatic test_mute;
        drain;
        clear_mon;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h4000, 4'($urandom_range(1, 15)), 1'b1);
            idle(1);
        end
        idle(8);
        tests_run++;
        if (got_q.size() != 5) begin
            tests_failed++;
            $display("FAIL mute_count: got %0d strobes, want 5", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== 16'h0000) begin
                tests_failed++;
                $display("FAIL mute_data[%0d]: got %h, want 0000", i, got_q[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] exp_q[$];
        logic [15:0] s;
        logic [3:0]  v;
        logic        m;
        drain;
        clear_mon;
        for (int i = 0; i < 60; i++) begin
            s = 16'($urandom);
            v = 4'($urandom_range(0, 15));
            m = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 7) begin
                step(1'b1, s, v, m);
                exp_q.push_back(ref_gain(s, v, m));
            end else begin
                step(1'b0, s, v, m);
            end
            idle(1);
        end
        idle(10);
        tests_run++;
        if (got_q.size() != exp_q.size() || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d strobes ovf=%b, want %0d ovf=0", got_q.size(), overflow, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i] || got_r[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rand_data[%0d]: got l=%h r=%h, want %h", i, got_q[i], got_r[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        bit seen;
        drain;
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom_range(1, 32767)), 4'd8, 1'b0);
        idle(3);
        clear_mon;
        audio_out_allowed = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            idle(1);
            if (write_audio_out === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL rstw_no_strobe: got no strobe within 10 cycles, want one");
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({write_audio_out, left_data, right_data, overflow, underrun, peak_level} !== '0) begin
            tests_failed++;
            $display("FAIL rstw_outputs: got wr=%b l=%h r=%h ovf=%b und=%b pk=%0d, want all 0",
                     write_audio_out, left_data, right_data, overflow, underrun, peak_level);
        end
        idle(2);
        reset = 1'b0;
        clear_mon;
        idle(10);
        tests_run++;
        if (got_q.size() != 0 || underrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstw_fifo_empty: got %0d strobes und=%b, want 0 strobes und=1", got_q.size(), underrun);
        end
    endtask

    task automatic test_peak;
        logic [3:0] want;
        bit seen;
        audio_out_allowed = 1'b1;
        clear_mon;
        step(1'b1, 16'h4000, 4'd8, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            idle(1);
            if (got_q.size() > 0) seen = 1'b1;
        end
`ifdef AUDIO_PEAK_METER_EN
        want = ref_level(16'h4000);
`else
        want = 4'd0;
`endif
        tests_run++;
        if (!seen || peak_level !== want) begin
            tests_failed++;
            $display("FAIL peak_load: got strobe=%0d peak=%0d, want strobe=1 peak=%0d", seen, peak_level, want);
        end
        idle(DECAY - 1);
        tests_run++;
        if (peak_level !== want) begin
            tests_failed++;
            $display("FAIL peak_hold: got %0d, want %0d", peak_level, want);
        end
        idle(1);
`ifdef AUDIO_PEAK_METER_EN
        want = want - 4'd1;
`endif
        tests_run++;
        if (peak_level !== want) begin
            tests_failed++;
            $display("FAIL peak_decay: got %0d, want %0d", peak_level, want);
        end
    endtask

    initial begin
        test_reset;
        test_passthrough;
        test_saturation;
        test_overflow;
        test_full_push_pop;
        test_underrun;
        test_mute;
        test_random;
        test_reset_mid_write;
        test_peak;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
